// File: rtl/keypad_pkg.sv
// keypad_pkg: shared types, default timing constants and width helpers for
// the keypad debouncer. Optional auto-repeat is enabled by KEYPAD_REPEAT_EN.
package keypad_pkg;

  // Per-channel debounce state machine encoding
  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    HELD         = 2'd2,
    RELEASE_WAIT = 2'd3
  } key_state_e;

  localparam int DEF_DEBOUNCE_CYCLES = 250000;
  localparam int DEF_REPEAT_DELAY    = 25000000;
  localparam int DEF_REPEAT_PERIOD   = 5000000;

  // Bits needed to hold values 0..max_val (at least one bit)
  function automatic int cnt_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Width of a key index for n keys (at least one bit)
  function automatic int code_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/keypad_debounce_ch.sv
// keypad_debounce_ch: one key channel -- 2-flop synchroniser, stability
// counter, debounce FSM and registered press/release pulses. With
// KEYPAD_REPEAT_EN defined a typematic repeat timer drives extra strobes.
//
// Handshake: none. Every output is a level (hold) or a single-cycle pulse
// (press, release_pulse, strobe) with no back-pressure; consumers must
// sample every cycle.
module keypad_debounce_ch
  import keypad_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
`ifdef KEYPAD_REPEAT_EN
  ,
  parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD
`endif
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_raw,
  output logic       hold,
  output logic       press,
  output logic       release_pulse,
  output logic       strobe,
  output key_state_e state
);

  localparam int CW = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync_meta;
  logic          sync;
  logic [CW-1:0] cnt;

  // Bring the asynchronous pin into the clock domain
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_meta <= 1'b0;
      sync      <= 1'b0;
    end else begin
      sync_meta <= key_raw;
      sync      <= sync_meta;
    end
  end

  // Debounce FSM; the counter tracks consecutive stable samples and is
  // cleared on every state entry, so it stops at CNT_LAST and never wraps
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      cnt           <= '0;
      hold          <= 1'b0;
      press         <= 1'b0;
      release_pulse <= 1'b0;
    end else begin
      press         <= 1'b0;
      release_pulse <= 1'b0;
      case (state)
        IDLE: begin
          if (sync) begin
            state <= PRESS_WAIT;
            cnt   <= '0;
          end
        end
        PRESS_WAIT: begin
          if (!sync) begin
            state <= IDLE;
            cnt   <= '0;
          end else if (cnt == CNT_LAST) begin
            state <= HELD;
            cnt   <= '0;
            hold  <= 1'b1;
            press <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        HELD: begin
          if (!sync) begin
            state <= RELEASE_WAIT;
            cnt   <= '0;
          end
        end
        RELEASE_WAIT: begin
          if (sync) begin
            // Bounce back to held: no pulses, hold never dropped
            state <= HELD;
            cnt   <= '0;
          end else if (cnt == CNT_LAST) begin
            state         <= IDLE;
            cnt           <= '0;
            hold          <= 1'b0;
            release_pulse <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
          hold  <= 1'b0;
        end
      endcase
    end
  end

`ifdef KEYPAD_REPEAT_EN
  localparam int RW = cnt_width(max_int(REPEAT_DELAY, REPEAT_PERIOD));
  localparam logic [RW-1:0] DELAY_LAST  = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] PERIOD_LAST = RW'(REPEAT_PERIOD - 1);

  logic [RW-1:0] rep_cnt;
  logic          rep_armed;
  logic          rep_pulse;

  // Typematic timer: restarts on a fresh press, runs only while the key
  // stays held, freezes during a release bounce, clears once idle
  always_ff @(posedge clk) begin
    if (rst) begin
      rep_cnt   <= '0;
      rep_armed <= 1'b0;
      rep_pulse <= 1'b0;
    end else begin
      rep_pulse <= 1'b0;
      if (state == PRESS_WAIT && sync && cnt == CNT_LAST) begin
        rep_cnt   <= '0;
        rep_armed <= 1'b0;
      end else if (state == HELD && sync) begin
        if (rep_cnt == (rep_armed ? PERIOD_LAST : DELAY_LAST)) begin
          rep_pulse <= 1'b1;
          rep_cnt   <= '0;
          rep_armed <= 1'b1;
        end else begin
          rep_cnt <= rep_cnt + 1'b1;
        end
      end else if (state == IDLE) begin
        rep_cnt   <= '0;
        rep_armed <= 1'b0;
      end
    end
  end

  assign strobe = press | rep_pulse;
`else
  assign strobe = press;
`endif

endmodule

// File: rtl/keypad_debounce.sv
// keypad_debounce: N independent debounce channels plus a combined
// any-held flag and a lowest-index priority encoder over the held keys.
// Define KEYPAD_REPEAT_EN to compile in typematic auto-repeat on strobe.
// The release event port is named release_pulse because 'release' is a
// reserved word in SystemVerilog.
module keypad_debounce
  import keypad_pkg::*;
#(
  parameter int N_KEYS          = 4,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD,
  localparam int KW             = code_width(N_KEYS)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_KEYS-1:0]      key_raw,
  output logic [N_KEYS-1:0]      hold,
  output logic [N_KEYS-1:0]      press,
  output logic [N_KEYS-1:0]      release_pulse,
  output logic [N_KEYS-1:0]      strobe,
  output logic                   any_hold,
  output logic [KW-1:0]          key_code,
  output logic [N_KEYS-1:0][1:0] dbg_state
);

  if (N_KEYS < 1 || N_KEYS > 32 || DEBOUNCE_CYCLES < 2 ||
      REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_params
    $error("keypad_debounce: parameter out of range");
  end

  for (genvar i = 0; i < N_KEYS; i++) begin : g_ch
    key_state_e ch_state;

    keypad_debounce_ch #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
`ifdef KEYPAD_REPEAT_EN
      ,
      .REPEAT_DELAY    (REPEAT_DELAY),
      .REPEAT_PERIOD   (REPEAT_PERIOD)
`endif
    ) u_ch (
      .clk           (clk),
      .rst           (rst),
      .key_raw       (key_raw[i]),
      .hold          (hold[i]),
      .press         (press[i]),
      .release_pulse (release_pulse[i]),
      .strobe        (strobe[i]),
      .state         (ch_state)
    );

    assign dbg_state[i] = ch_state;
  end

  assign any_hold = |hold;

  // Lowest-numbered held key wins; zero when nothing is held
  always_comb begin
    key_code = '0;
    for (int i = N_KEYS - 1; i >= 0; i--) begin
      if (hold[i]) key_code = KW'(i);
    end
  end

endmodule

// File: doc/keypad_debounce.md
# keypad_debounce

Parametrised N-channel key debouncer with per-key press/release event pulses and optional typematic auto-repeat. Sits between the raw push-button pins and the game logic, replacing the single shared-timer 4-key debouncer. Each channel has its own synchroniser, stability counter and state machine, so keys debounce independently and simultaneous presses are resolved per key.

## Interface
- N_KEYS, 4, number of key channels (1..32)
- DEBOUNCE_CYCLES, 250000, consecutive stable samples required to accept a level change (>=2)
- REPEAT_DELAY, 25000000, cycles from accepted press to first repeat strobe (>=1, used only with repeat compiled in)
- REPEAT_PERIOD, 5000000, cycles between subsequent repeat strobes (>=1)
- clk  input  1  system clock; all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- key_raw  input  N_KEYS  asynchronous active-high button levels
- hold  output  N_KEYS  debounced level per key
- press  output  N_KEYS  one-cycle pulse per accepted press
- release  output  N_KEYS  one-cycle pulse per accepted release
- strobe  output  N_KEYS  one-cycle pulse on press and on each auto-repeat
- any_hold  output  1  OR of hold
- key_code  output  max(1,clog2(N_KEYS))  index of lowest-numbered held key; 0 when any_hold=0

## Operation
- Each key_raw bit passes through a 2-flop synchroniser (reset to 0); debouncing uses the second flop (sync).
- Per-channel FSM: IDLE -> PRESS_WAIT when sync=1; PRESS_WAIT -> HELD when sync stayed 1 for DEBOUNCE_CYCLES consecutive cycles; PRESS_WAIT -> IDLE on any sync=0 (counter cleared, no pulse).
- HELD -> RELEASE_WAIT when sync=0; RELEASE_WAIT -> IDLE after DEBOUNCE_CYCLES consecutive sync=0; RELEASE_WAIT -> HELD on any sync=1 (no press, no release pulse).
- hold=1 in HELD and RELEASE_WAIT only. press and strobe pulse on the IDLE/PRESS_WAIT -> HELD transition; release pulses on RELEASE_WAIT -> IDLE.
- Stability counter width clog2(DEBOUNCE_CYCLES+1); cleared on every state entry; never wraps.
- Channels are fully independent; any number may transition in the same cycle, each producing its own pulse.
- key_code/any_hold are combinational from registered hold.

## Timing
- Reset: all FSMs IDLE, counters 0, synchronisers 0; hold, press, release, strobe, any_hold, key_code all 0 in the cycle after rst is sampled high.
- Press latency: key_raw sampled high at edge k (stable) -> hold and press high after edge k+1+DEBOUNCE_CYCLES+1, i.e. DEBOUNCE_CYCLES+2 cycles; release latency identical.
- A single-cycle glitch shorter than DEBOUNCE_CYCLES never changes hold.
- Reset mid-operation: pending counts discarded, no release pulse issued; a key still held after rst falls re-debounces and gives a fresh press.
- rst has priority over all transitions in the same cycle.

## Configuration
- KEYPAD_REPEAT_EN defined: per-channel repeat timer (width clog2(max(REPEAT_DELAY,REPEAT_PERIOD)+1)) cleared on entry to HELD from PRESS_WAIT; counts only in HELD (frozen in RELEASE_WAIT, resumes on bounce back); strobe pulses REPEAT_DELAY cycles after press, then every REPEAT_PERIOD cycles while held; timer cleared in IDLE.
- Undefined: no repeat timer; strobe is identical to press; REPEAT_* parameters ignored.

## Structure
- Package keypad_pkg: FSM state enum (IDLE, PRESS_WAIT, HELD, RELEASE_WAIT), counter-width helper function, default constants for DEBOUNCE_CYCLES/REPEAT_DELAY/REPEAT_PERIOD.
- Sub-module keypad_debounce_ch: one channel (synchroniser, FSM, counters, pulses), instantiated N_KEYS times by a generate loop; top holds only the priority encoder and OR.

## Test plan
Use N_KEYS=4, DEBOUNCE_CYCLES=8, REPEAT_DELAY=20, REPEAT_PERIOD=5.
- Reset: rst high 2 cycles with key_raw=4'b1111 -> all outputs 0; after rst low, press=4'b1111 exactly 10 cycles later, one cycle wide.
- Bounce: key_raw[1] toggles every 3 cycles for 30 cycles then stays 1 -> no pulse during toggling, single press[1] 10 cycles after final rise, key_code=1.
- Release glitch: key 2 held, key_raw[2] low 5 cycles then high -> hold[2] stays 1, no release/press; low 12 cycles -> release[2] pulse 10 cycles after fall.
- Simultaneous: keys 0 and 3 rise same cycle -> press=4'b1001 same cycle, key_code=0; release key 0 -> key_code=3.
- Repeat (KEYPAD_REPEAT_EN): hold key 0 for 40 cycles after press -> strobe[0] at press+0, +20, +25, +30, +35; without macro strobe[0] only at press.
- Reset mid-hold: rst pulse while hold[3]=1 -> outputs 0 next cycle, no release pulse; key still down -> press[3] 10 cycles after rst falls.
